prime_check: RTL and testbench
==============================

Name: prime_check

Overview:
- Responder for the go/ready/error handshake used by the board-level drivers.
- The requester presents a candidate n with a one-cycle go pulse.
- The block runs iterative trial division, then reports whether n is prime and, if not, its smallest factor.
- Sits beside the prime generator so board tops can verify generated values or test user-supplied numbers.

Parameters:
- HI, 15, MSB index of n and factor; W = HI+1 bits of operand.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- go  input  1  start request; sampled on clk; n is captured in the same cycle.
- n  input  W  candidate to test.
- ready  output  1  1 = idle, results valid, go accepted.
- error  output  1  sticky protocol-violation flag.
- is_prime  output  1  1 = last n was prime.
- factor  output  W  smallest divisor >1 of last n; 0 if prime or n<2.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; ready=1, error=0, is_prime=0, factor=0; internal registers cleared. Reset mid-computation aborts it with no result update.
- Registers:
  - nr: latched n, W bits.
  - d: trial divisor, W+1 bits.
  - sq: d*d, 2W bits, maintained incrementally; no multiplier.
  - rem: remainder, W+1 bits.
  - bit counter over 0..W-1.
- States: IDLE, CHECK, DIV, NEXT, ERR.
- IDLE:
  - go=1 → nr<=n, d<=2, sq<=4, ready<=0, go to CHECK.
  - is_prime and factor hold their last values until a result is written.
- CHECK (1 cycle):
  - if nr<2 → is_prime<=0, factor<=0, ready<=1, IDLE;
  - else if sq>nr → is_prime<=1, factor<=0, ready<=1, IDLE;
  - else clear rem, go to DIV.
- DIV: restoring shift-subtract of nr by d, MSB first. Exactly W cycles, then NEXT.
- NEXT (1 cycle):
  - if rem==0 → is_prime<=0, factor<=d, ready<=1, IDLE;
  - else sq<=sq+2d+1, d<=d+1, go to CHECK.
- Latency: k = number of divisors tried.
  - Prime or n<4: ready low for k*(W+2)+1 cycles (k=0 for n<4).
  - Composite: ready low for k*(W+2) cycles.
- Results are updated on the same edge ready rises, and are stable while ready=1.
- go while ready=0 (busy):
  - enter ERR: error<=1, ready<=0, is_prime<=0, factor<=0;
  - the in-flight computation is discarded;
  - ERR is left only by reset.
- Boundaries:
  - n=0,1 → not prime, factor 0.
  - n=2,3 → prime after 1 cycle.
  - n=4 → factor 2.
  - n=2^W-1 handled without overflow: sq width 2W, d width W+1.

Optional Feature:
- Macro: PRIME_CHECK_ODD_ONLY_EN
- Defined:
  - After d=2, divisors step by 2 (3,5,7,...).
  - In NEXT: d=2 → d<=3, sq<=9; otherwise d<=d+2, sq<=sq+4d+4.
- Undefined: step by 1 as above.
- Outputs are identical either way; only k (and thus latency) differs.

Test Plan:
- Reset release, n=0, go → 1 cycle later ready=1, is_prime=0, factor=0, error=0.
- HI=15, n=97, go → ready low 145 cycles (k=8), then is_prime=1, factor=0. With PRIME_CHECK_ODD_ONLY_EN: 91 cycles (k=5).
- n=91, go → ready low 108 cycles (k=6), then is_prime=0, factor=7. With PRIME_CHECK_ODD_ONLY_EN: 72 cycles (k=4).
- n=65521, go → ready low 4573 cycles, is_prime=1. With PRIME_CHECK_ODD_ONLY_EN: 2305 cycles. n=65535 → factor=3.
- n=97 go, then a second go 10 cycles later → error=1, ready=0, is_prime=0, factor=0 held 1000 cycles. rst=0 → ready=1, error=0 immediately, without waiting for a clock edge.
- rst pulsed low during DIV of n=91 → IDLE with outputs at reset values. A subsequent n=4 → factor=2.

Source files
------------

// File: rtl/prime_check_if.sv
// Request/result bundle between a requester and prime_check.
// The requester pulses go with n; the responder reports ready, error, is_prime and factor.
interface prime_check_if #(
    parameter int HI = 15
);
    logic          go;
    logic [HI:0]   n;
    logic          ready;
    logic          error;
    logic          is_prime;
    logic [HI:0]   factor;

    modport master (output go, n, input ready, error, is_prime, factor);
    modport slave  (input go, n, output ready, error, is_prime, factor);
endinterface

// File: rtl/prime_check.sv
// Iterative trial-division primality checker with a go/ready/error handshake.
// Define PRIME_CHECK_ODD_ONLY_EN to try only 2 and the odd divisors (same results, shorter latency).
module prime_check #(
    parameter int HI = 15
) (
    input  logic         clk,
    input  logic         rst,
    prime_check_if.slave bus
);
    localparam int W  = HI + 1;
    localparam int CW = $clog2(W);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CHECK = 3'd1;
    localparam logic [2:0] DIV   = 3'd2;
    localparam logic [2:0] NEXT  = 3'd3;
    localparam logic [2:0] ERR   = 3'd4;

    logic [2:0]     state;
    logic [HI:0]    nr;
    logic [W:0]     d;
    logic [2*W-1:0] sq;
    logic [W:0]     rem;
    logic [CW-1:0]  cnt;

    logic           ready_q;
    logic           error_q;
    logic           is_prime_q;
    logic [HI:0]    factor_q;

    logic [CW-1:0]  idx;
    logic [W+1:0]   trial;
    logic           fits;
    logic [W+1:0]   diff;

    // One restoring-division step: bring down the next bit of nr, subtract d if it fits.
    always_comb begin
        idx   = CW'(HI) - cnt;
        trial = {rem, nr[idx]};
        fits  = trial >= {1'b0, d};
        diff  = trial - {1'b0, d};
    end

    // NOTE: state is updated with non-blocking assignments so every branch reads
    // the values from before this edge, regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            nr         <= '0;
            d          <= '0;
            sq         <= '0;
            rem        <= '0;
            cnt        <= '0;
            ready_q    <= 1'b1;
            error_q    <= 1'b0;
            is_prime_q <= 1'b0;
            factor_q   <= '0;
        end else if (bus.go && !ready_q) begin
            // A request while busy poisons the block until the next reset.
            state      <= ERR;
            error_q    <= 1'b1;
            ready_q    <= 1'b0;
            is_prime_q <= 1'b0;
            factor_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.go) begin
                        nr      <= bus.n;
                        d       <= (W+1)'(2);
                        sq      <= (2*W)'(4);
                        ready_q <= 1'b0;
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    if (nr < HI'(2)) begin
                        is_prime_q <= 1'b0;
                        factor_q   <= '0;
                        ready_q    <= 1'b1;
                        state      <= IDLE;
                    end else if (sq > (2*W)'(nr)) begin
                        is_prime_q <= 1'b1;
                        factor_q   <= '0;
                        ready_q    <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        rem   <= '0;
                        cnt   <= '0;
                        state <= DIV;
                    end
                end
                DIV: begin
                    rem <= fits ? diff[W:0] : trial[W:0];
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(HI)) state <= NEXT;
                end
                NEXT: begin
                    if (rem == '0) begin
                        is_prime_q <= 1'b0;
                        factor_q   <= d[HI:0];
                        ready_q    <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        // sq tracks d*d by adding (d+s)^2 - d^2, so no multiplier is needed.
`ifdef PRIME_CHECK_ODD_ONLY_EN
                        if (d == (W+1)'(2)) begin
                            d  <= (W+1)'(3);
                            sq <= (2*W)'(9);
                        end else begin
                            d  <= d + (W+1)'(2);
                            sq <= sq + (2*W)'({d, 2'b00}) + (2*W)'(4);
                        end
`else
                        d  <= d + (W+1)'(1);
                        sq <= sq + (2*W)'({d, 1'b1});
`endif
                        state <= CHECK;
                    end
                end
                ERR:     state <= ERR;
                default: state <= ERR;
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.error    = error_q;
    assign bus.is_prime = is_prime_q;
    assign bus.factor   = factor_q;
endmodule

// File: tb/tb_prime_check.sv
// Directed bench for prime_check: results, exact busy latency, protocol error and async reset.
module tb_prime_check;
    localparam int HI    = 15;
    localparam int BOUND = 10000;

`ifdef PRIME_CHECK_ODD_ONLY_EN
    localparam int L97    = 91;
    localparam int L91    = 72;
    localparam int L65521 = 2305;
`else
    localparam int L97    = 145;
    localparam int L91    = 108;
    localparam int L65521 = 4573;
`endif

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   lat;
    logic stable;

    prime_check_if #(.HI(HI)) bus ();

    prime_check #(.HI(HI)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [HI:0] val);
        @(negedge clk);
        bus.n  = val;
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
    endtask

    // Counts the cycles ready stays low after go; returns BOUND on timeout.
    task automatic run(input logic [HI:0] val, output int cycles);
        start(val);
        cycles = 0;
        while (!bus.ready && cycles < BOUND) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic expect_result(input string tag, input logic [HI:0] val, input int exp_lat,
                                 input logic exp_prime, input logic [HI:0] exp_factor);
        int cyc;
        run(val, cyc);
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " is_prime"}, 32'(bus.is_prime), 32'(exp_prime));
        check({tag, " factor"}, 32'(bus.factor), 32'(exp_factor));
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        rst    = 1'b0;
        bus.go = 1'b0;
        bus.n  = '0;
        #12;
        check("reset ready", 32'(bus.ready), 32'd1);
        check("reset error", 32'(bus.error), 32'd0);
        check("reset is_prime", 32'(bus.is_prime), 32'd0);
        check("reset factor", 32'(bus.factor), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        expect_result("n0", 16'd0, 1, 1'b0, 16'd0);
        check("n0 error", 32'(bus.error), 32'd0);
        expect_result("n1", 16'd1, 1, 1'b0, 16'd0);
        expect_result("n2", 16'd2, 1, 1'b1, 16'd0);
        expect_result("n3", 16'd3, 1, 1'b1, 16'd0);
        expect_result("n4", 16'd4, 18, 1'b0, 16'd2);
        expect_result("n97", 16'd97, L97, 1'b1, 16'd0);
        expect_result("n91", 16'd91, L91, 1'b0, 16'd7);
        expect_result("n65521", 16'd65521, L65521, 1'b1, 16'd0);
        expect_result("n65535", 16'd65535, 36, 1'b0, 16'd3);

        // Second go while busy: sticky error, results cleared.
        start(16'd97);
        repeat (9) @(negedge clk);
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        check("err error", 32'(bus.error), 32'd1);
        check("err ready", 32'(bus.ready), 32'd0);
        check("err is_prime", 32'(bus.is_prime), 32'd0);
        check("err factor", 32'(bus.factor), 32'd0);
        stable = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.error !== 1'b1 || bus.ready !== 1'b0 ||
                bus.is_prime !== 1'b0 || bus.factor !== '0)
                stable = 1'b0;
        end
        check("err held 1000", 32'(stable), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("err rst ready", 32'(bus.ready), 32'd1);
        check("err rst error", 32'(bus.error), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Reset in the middle of a division discards it.
        expect_result("pre97", 16'd97, L97, 1'b1, 16'd0);
        start(16'd91);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort ready", 32'(bus.ready), 32'd1);
        check("abort error", 32'(bus.error), 32'd0);
        check("abort is_prime", 32'(bus.is_prime), 32'd0);
        check("abort factor", 32'(bus.factor), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        expect_result("post4", 16'd4, 18, 1'b0, 16'd2);

        run(16'd13, lat);
        check("n13 latency", lat, 37);
        check("n13 is_prime", 32'(bus.is_prime), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
